// File: rtl/adc_test_pattern_gen.sv
// ADC test pattern generator.
// Drives NUM_CH signed ramp channels plus a periodic one-cycle trigger in place
// of the ADC front end, so on-board self-test sees the same stimulus as the
// simulation bench. Configured through the sys register bus.
//
// Optional build feature: define TPG_PRBS_EN to add a per-channel PRBS-15
// source selectable with CTRL[2]. Without it CTRL[2] reads 0 and no LFSR
// logic exists.
//
// sys bus handshake: sys_wen/sys_ren are single-cycle strobes sampled on the
// rising edge; sys_ack is high for exactly one cycle on the following cycle
// with sys_rdata valid alongside it. There is no back-pressure. A cycle with
// both strobes performs the write, returns the pre-write value and acks once.
module adc_test_pattern_gen #(
    parameter int NUM_CH = 2,
    parameter int DW     = 14,
    parameter int TCW    = 16
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    output logic [NUM_CH*DW-1:0] adc_dat_o,
    output logic                 adc_dv_o,
    output logic                 trig_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_err,
    output logic                 sys_ack
);

    localparam logic signed [DW-1:0] MIN_RST    = DW'(-1000);
    localparam logic signed [DW-1:0] MAX_RST    = DW'(1000);
    localparam logic        [DW-1:0] STEP_RST   = DW'(1);
    localparam logic       [TCW-1:0] PERIOD_RST = TCW'(25000);

    // Configuration registers
    logic                 ctrl_en;
    logic                 restart_q;
    logic [TCW-1:0]       period;
    logic signed [DW-1:0] min_r  [NUM_CH];
    logic signed [DW-1:0] max_r  [NUM_CH];
    logic [DW-1:0]        step_r [NUM_CH];

    // Pattern state
    logic signed [DW-1:0] cur     [NUM_CH];
    logic signed [DW-1:0] cur_nxt [NUM_CH];
    logic signed [DW-1:0] dat_q   [NUM_CH];
    logic signed [DW-1:0] dat_nxt [NUM_CH];
    logic [TCW-1:0]       tcnt;
    logic [TCW-1:0]       tcnt_nxt;
    logic                 trig_nxt;

    logic [5:0]           reg_addr;
    logic [31:0]          rd_val;

`ifdef TPG_PRBS_EN
    logic                 ctrl_mode;
    logic [14:0]          lfsr     [NUM_CH];
    logic [14:0]          lfsr_nxt [NUM_CH];
`endif

    // Upper address bits and unused data bits are deliberately ignored.
    logic unused_bus;
    assign unused_bus = ^{sys_addr[31:6], sys_wdata};

    assign reg_addr = sys_addr[5:0];
    assign sys_err  = 1'b0;

    function automatic logic [5:0] minmax_addr(input int ch);
        return 6'(16 + 8 * ch);
    endfunction

    function automatic logic [5:0] step_addr(input int ch);
        return 6'(20 + 8 * ch);
    endfunction

    // One ramp step: wrap at/above MAX, otherwise add STEP and clamp to MAX.
    // The sum carries two extra bits so a full-range unsigned STEP can never
    // wrap around and slip under the MAX comparison.
    function automatic logic signed [DW-1:0] ramp_next(
        input logic signed [DW-1:0] c,
        input logic signed [DW-1:0] mn,
        input logic signed [DW-1:0] mx,
        input logic        [DW-1:0] st
    );
        logic signed [DW+1:0] sum;
        logic signed [DW+1:0] mx_ext;
        logic signed [DW-1:0] res;
        mx_ext = (DW+2)'(mx);
        sum    = (DW+2)'(c) + $signed({2'b00, st});
        if (c >= mx) begin
            res = mn;
        end else if (sum > mx_ext) begin
            res = mx;
        end else begin
            res = sum[DW-1:0];
        end
        return res;
    endfunction

`ifdef TPG_PRBS_EN
    function automatic logic [14:0] lfsr_seed(input int ch);
        return 15'h7FFF ^ 15'(ch);
    endfunction

    // x^15 + x^14 + 1, shifting towards the MSB.
    function automatic logic [14:0] lfsr_step(input logic [14:0] l);
        return {l[13:0], l[14] ^ l[13]};
    endfunction

    // Sample view of the LFSR: low DW bits, zero-extended when DW > 15.
    function automatic logic signed [DW-1:0] prbs_view(input logic [14:0] l);
        logic [31:0] w;
        w = {17'b0, l};
        return w[DW-1:0];
    endfunction
`endif

    // Register file writes; restart is a one-cycle pulse consumed next edge.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            ctrl_en   <= 1'b0;
            restart_q <= 1'b0;
            period    <= PERIOD_RST;
`ifdef TPG_PRBS_EN
            ctrl_mode <= 1'b0;
`endif
            for (int ch = 0; ch < NUM_CH; ch++) begin
                min_r[ch]  <= MIN_RST;
                max_r[ch]  <= MAX_RST;
                step_r[ch] <= STEP_RST;
            end
        end else begin
            restart_q <= 1'b0;
            if (sys_wen) begin
                if (reg_addr == 6'h00) begin
                    ctrl_en   <= sys_wdata[0];
                    restart_q <= sys_wdata[1];
`ifdef TPG_PRBS_EN
                    ctrl_mode <= sys_wdata[2];
`endif
                end
                if (reg_addr == 6'h04) begin
                    period <= sys_wdata[TCW-1:0];
                end
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (reg_addr == minmax_addr(ch)) begin
                        min_r[ch] <= sys_wdata[DW-1:0];
                        max_r[ch] <= sys_wdata[16+DW-1:16];
                    end
                    if (reg_addr == step_addr(ch)) begin
                        step_r[ch] <= sys_wdata[DW-1:0];
                    end
                end
            end
        end
    end

    // Read mux over the current (pre-write) register image; unmapped reads 0.
    always_comb begin
        rd_val = '0;
        if (reg_addr == 6'h00) begin
            rd_val[0] = ctrl_en;
`ifdef TPG_PRBS_EN
            rd_val[2] = ctrl_mode;
`endif
        end
        if (reg_addr == 6'h04) begin
            rd_val[TCW-1:0] = period;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (reg_addr == minmax_addr(ch)) begin
                rd_val[DW-1:0]     = min_r[ch];
                rd_val[16+DW-1:16] = max_r[ch];
            end
            if (reg_addr == step_addr(ch)) begin
                rd_val[DW-1:0] = step_r[ch];
            end
        end
    end

    // Bus response: one ack per strobe cycle, read data only with a read.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rd_val : '0;
        end
    end

    // Next ramp values and trigger counter; restart overrides everything.
    always_comb begin
        tcnt_nxt = tcnt;
        trig_nxt = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cur_nxt[ch] = cur[ch];
        end
        if (restart_q) begin
            tcnt_nxt = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cur_nxt[ch] = min_r[ch];
            end
        end else if (ctrl_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cur_nxt[ch] = ramp_next(cur[ch], min_r[ch], max_r[ch], step_r[ch]);
            end
            if (tcnt == period) begin
                trig_nxt = 1'b1;
                tcnt_nxt = '0;
            end else begin
                tcnt_nxt = tcnt + TCW'(1);
            end
        end
    end

`ifdef TPG_PRBS_EN
    // Next LFSR values: reseed on restart, advance on enabled cycles.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            lfsr_nxt[ch] = lfsr[ch];
            if (restart_q) begin
                lfsr_nxt[ch] = lfsr_seed(ch);
            end else if (ctrl_en) begin
                lfsr_nxt[ch] = lfsr_step(lfsr[ch]);
            end
        end
    end

    // LFSR state register.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                lfsr[ch] <= lfsr_seed(ch);
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                lfsr[ch] <= lfsr_nxt[ch];
            end
        end
    end

    // Output sample selection between ramp and PRBS.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dat_nxt[ch] = ctrl_mode ? prbs_view(lfsr_nxt[ch]) : cur_nxt[ch];
        end
    end
`else
    // Output sample is always the ramp.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dat_nxt[ch] = cur_nxt[ch];
        end
    end
`endif

    // Pattern and output registers; data, valid and trigger share one edge.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            tcnt     <= '0;
            trig_o   <= 1'b0;
            adc_dv_o <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cur[ch]   <= MIN_RST;
                dat_q[ch] <= MIN_RST;
            end
        end else begin
            tcnt     <= tcnt_nxt;
            trig_o   <= trig_nxt;
            adc_dv_o <= ctrl_en;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cur[ch]   <= cur_nxt[ch];
                dat_q[ch] <= dat_nxt[ch];
            end
        end
    end

    // Pack channels onto the output bus, channel 0 in the LSBs.
    always_comb begin
        adc_dat_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            adc_dat_o[ch*DW +: DW] = dat_q[ch];
        end
    end

endmodule

// File: tb/tb_adc_test_pattern_gen.sv
// Bench for adc_test_pattern_gen: a cycle-level behavioural model built from
// the block's register/ramp/trigger rules, compared every cycle, plus directed
// sequences with hand-computed literal expectations.
module tb_adc_test_pattern_gen;

  localparam int NUM_CH = 2;
  localparam int DW     = 14;
  localparam int TCW    = 16;
  localparam int MASK   = (1 << DW) - 1;

  // ---------------- clock / reset ----------------
  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH*DW-1:0] adc_dat;
  logic                 adc_dv;
  logic                 trig;
  logic [31:0]          sys_addr;
  logic [31:0]          sys_wdata;
  logic                 sys_wen;
  logic                 sys_ren;
  logic [31:0]          sys_rdata;
  logic                 sys_err;
  logic                 sys_ack;

  int n_vec  = 0;
  int n_fail = 0;

  adc_test_pattern_gen #(.NUM_CH(NUM_CH), .DW(DW), .TCW(TCW)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rst_n),
    .adc_dat_o  (adc_dat),
    .adc_dv_o   (adc_dv),
    .trig_o     (trig),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int ch_val(input int ch);
    return int'($signed(adc_dat[ch*DW +: DW]));
  endfunction

  // ---------------- behavioural model ----------------
  int m_min [NUM_CH];
  int m_max [NUM_CH];
  int m_step[NUM_CH];
  int m_cur [NUM_CH];
  int m_lfsr[NUM_CH];
  int m_period, m_tcnt;
  bit m_en, m_mode, m_pend;
  int e_dat [NUM_CH];
  bit e_dv, e_trig, e_ack;
  int e_rdata;

  function automatic int sx(input int v);
    int r;
    r = v & MASK;
    if (r >= (1 << (DW - 1))) r = r - (1 << DW);
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_pend = 0;
    m_period = 25000; m_tcnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_min[c] = -1000; m_max[c] = 1000; m_step[c] = 1;
      m_cur[c] = -1000; m_lfsr[c] = 32'h7FFF ^ c; e_dat[c] = -1000;
    end
    e_dv = 0; e_trig = 0; e_ack = 0; e_rdata = 0;
  endtask

  function automatic int model_read(input int a_in);
    int a;
    int r;
    a = a_in & 63;
    r = 0;
    if (a == 0) r = int'(m_en) | (int'(m_mode) << 2);
    if (a == 4) r = m_period;
    for (int c = 0; c < NUM_CH; c++) begin
      if (a == 16 + 8 * c) r = (m_min[c] & MASK) | ((m_max[c] & MASK) << 16);
      if (a == 20 + 8 * c) r = m_step[c];
    end
    return r;
  endfunction

  task automatic model_step();
    int rd, a, wd, s;
    bit trg;
    rd  = model_read(int'(sys_addr));
    a   = int'(sys_addr) & 63;
    wd  = int'(sys_wdata);
    trg = 0;
    if (m_pend) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cur[c] = m_min[c];
        m_lfsr[c] = 32'h7FFF ^ c;
      end
      m_tcnt = 0;
    end else if (m_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_cur[c] >= m_max[c]) m_cur[c] = m_min[c];
        else begin
          s = m_cur[c] + m_step[c];
          m_cur[c] = (s > m_max[c]) ? m_max[c] : s;
        end
        m_lfsr[c] = ((m_lfsr[c] << 1) | (((m_lfsr[c] >> 14) ^ (m_lfsr[c] >> 13)) & 1)) & 32'h7FFF;
      end
      if (m_tcnt == m_period) begin
        trg = 1; m_tcnt = 0;
      end else begin
        m_tcnt = (m_tcnt + 1) & ((1 << TCW) - 1);
      end
    end
    for (int c = 0; c < NUM_CH; c++) e_dat[c] = m_mode ? sx(m_lfsr[c]) : m_cur[c];
    e_trig = trg;
    e_dv   = m_en;
    m_pend = 0;
    if (sys_wen) begin
      if (a == 0) begin
        m_en = wd[0];
        m_pend = wd[1];
`ifdef TPG_PRBS_EN
        m_mode = wd[2];
`endif
      end
      if (a == 4) m_period = wd & ((1 << TCW) - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (a == 16 + 8 * c) begin
          m_min[c] = sx(wd);
          m_max[c] = sx(wd >>> 16);
        end
        if (a == 20 + 8 * c) m_step[c] = wd & MASK;
      end
    end
    e_ack   = sys_wen | sys_ren;
    e_rdata = sys_ren ? rd : 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard: every cycle, away from the active edge ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) chk($sformatf("model_dat_ch%0d", c), ch_val(c), e_dat[c]);
      chk("model_dv", int'(adc_dv), int'(e_dv));
      chk("model_trig", int'(trig), int'(e_trig));
      chk("model_ack", int'(sys_ack), int'(e_ack));
      chk("model_rdata", int'(sys_rdata), e_rdata);
      chk("model_err", int'(sys_err), 0);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic bus_write(input int a, input int d);
    sys_addr = 32'(a); sys_wdata = 32'(d); sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_read_chk(input string name, input int a, input int exp);
    int n;
    sys_addr = 32'(a); sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    n = 0;
    while (!sys_ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!sys_ack) chk({name, "_ack_timeout"}, 0, 1);
    else chk(name, int'(sys_rdata), exp);
  endtask

  // ---------------- directed stimulus ----------------
  int n;
  int seq4[6] = '{-8, -1, 6, 10, -8, -1};

  initial begin
    rst_n = 1'b1; sys_addr = '0; sys_wdata = '0; sys_wen = 1'b0; sys_ren = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dat_ch0", ch_val(0), -1000);
    chk("rst_dat_ch1", ch_val(1), -1000);
    chk("rst_dv", int'(adc_dv), 0);
    chk("rst_trig", int'(trig), 0);
    rst_n = 1'b1;

    // reset register image
    bus_read_chk("rd_ctrl", 32'h00, 0);
    bus_read_chk("rd_period", 32'h04, 25000);
    bus_read_chk("rd_minmax0", 32'h10, 32'h03E8_3C18);
    bus_read_chk("rd_step0", 32'h14, 1);
    bus_read_chk("rd_minmax1", 32'h18, 32'h03E8_3C18);
    bus_read_chk("rd_step1", 32'h1C, 1);
    bus_read_chk("rd_unmapped", 32'h3C, 0);

    // default ramp over a full period, trigger every 5 cycles with PERIOD=4
    bus_write(32'h04, 4);
    bus_write(32'h00, 1);
    for (int k = 1; k <= 2002; k++) begin
      @(negedge clk);
      chk("ramp_ch0", ch_val(0), (k <= 2000) ? (-1000 + k) : (-1000 + (k - 2001)));
      chk("trig_p4", int'(trig), (k % 5 == 0) ? 1 : 0);
      if (k == 1) chk("dv_on", int'(adc_dv), 1);
    end
    n = 2002;

    // restart landing on the cycle that would have triggered
    while ((n + 2) % 5 != 0) begin
      @(negedge clk);
      n++;
    end
    bus_write(32'h00, 3);
    @(negedge clk);
    chk("restart_trig", int'(trig), 0);
    chk("restart_ch0", ch_val(0), -1000);
    chk("restart_ch1", ch_val(1), -1000);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("post_restart_ch0", ch_val(0), -1000 + j);
      chk("post_restart_trig", int'(trig), (j == 5) ? 1 : 0);
    end

    // saturate then wrap: MIN=-8 MAX=10 STEP=7
    bus_write(32'h10, 32'h000A_3FF8);
    bus_write(32'h14, 7);
    bus_write(32'h00, 3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("sat_wrap_ch0", ch_val(0), seq4[k]);
    end

    // MIN > MAX on ch1: stuck at MIN
    bus_write(32'h18, ((-5 & MASK) << 16) | 5);
    bus_write(32'h00, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("min_gt_max_ch1", ch_val(1), 5);
    end

    // simultaneous write and read: pre-write value, one ack
    sys_addr = 32'h04; sys_wdata = 32'd7; sys_wen = 1'b1; sys_ren = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0; sys_ren = 1'b0;
    chk("wr_rd_ack", int'(sys_ack), 1);
    chk("wr_rd_old", int'(sys_rdata), 4);
    @(negedge clk);
    chk("wr_rd_single_ack", int'(sys_ack), 0);
    bus_read_chk("rd_period_new", 32'h04, 7);
    bus_write(32'h20, 32'h1234);
    bus_read_chk("rd_unmapped_after_wr", 32'h20, 0);

    // disable holds; restart still honoured while disabled
    bus_write(32'h00, 0);
    repeat (3) @(negedge clk);
    chk("dis_dv", int'(adc_dv), 0);
    chk("dis_trig", int'(trig), 0);
    bus_write(32'h00, 2);
    @(negedge clk);
    chk("dis_restart_ch0", ch_val(0), -8);
    chk("dis_restart_dv", int'(adc_dv), 0);

    // mode bit
    bus_write(32'h00, 5);
`ifdef TPG_PRBS_EN
    bus_read_chk("rd_ctrl_mode", 32'h00, 5);
    bus_write(32'h00, 7);
    @(negedge clk);
    chk("prbs_seed_ch0", ch_val(0), -1);
    chk("prbs_seed_ch1", ch_val(1), -2);
    @(negedge clk);
    chk("prbs_step1_ch0", ch_val(0), -2);
    repeat (40) @(negedge clk);
    bus_write(32'h00, 1);
`else
    bus_read_chk("rd_ctrl_mode", 32'h00, 1);
    @(negedge clk);
    chk("mode_ignored_dv", int'(adc_dv), 1);
`endif
    repeat (10) @(negedge clk);

    // asynchronous reset mid-operation kills a pending ack
    sys_addr = 32'h04; sys_wdata = 32'd9; sys_wen = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sys_wen = 1'b0;
    @(negedge clk);
    chk("midrst_ack", int'(sys_ack), 0);
    chk("midrst_ch0", ch_val(0), -1000);
    chk("midrst_dv", int'(adc_dv), 0);
    rst_n = 1'b1;
    bus_read_chk("midrst_period", 32'h04, 25000);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
